stack_cpu: RTL
==============

# stack_cpu

Parametrised multicycle stack-machine core: fetches 4-bit-opcode instructions from a synchronous single-port RAM and executes them against an external first-word-fall-through stack. Successor to the fixed 8-bit core, adding width/depth parameters, stack overflow/underflow and illegal-opcode trapping, a HALT instruction and flag visibility. Sits between the program/data RAM and the stack block at the top level of the lab processor.

## Interface
- DW, 8: data word width (RAM and stack), ≥ AW, ≥ 4
- AW, 8: RAM address / PC width
- RESET_PC, 0: PC value after reset
- clk  in  1  system clock, rising edge
- resetN  in  1  reset, asynchronous assert, active-low; one clock, reset asynchronous and active-low
- haltN  in  1  0 = freeze core (no state change, no strobes)
- ram_address  out  AW  RAM address
- ram_readWriteN  out  1  1 = read, 0 = write this cycle
- ram_data_out  out  DW  RAM write data
- ram_data_in  in  DW  RAM read data, valid 1 cycle after address presented with read
- stack_data_out  out  DW  push data
- stack_data_in  in  DW  top of stack (FWFT, combinational)
- stack_push, stack_pop  out  1  single-cycle strobes
- stack_full, stack_empty  in  1  stack status
- z_flag, s_flag  out  1  zero / sign of last ADD/SUB result
- halted  out  1  core executed HALT
- error  out  1  core trapped; err_code  out  2  1 underflow, 2 overflow, 3 illegal opcode

## Operation
- Opcode = instr[3:0]. 0 PUSHC imm; 1 PUSH addr (push mem[addr]); 2 POP addr (mem[addr] = pop); 3 JUMP (pc = pop); 4 JZ (t = pop; if z pc = t); 5 JS (same on s); 6 ADD; 7 SUB; 8 HALT; 9–15 illegal. Opcodes 0–2 carry one operand word at pc+1.
- ADD/SUB: a = first pop, b = second pop, push b+a / b−a mod 2^DW; z = (result==0), s = result[DW-1]. Only ADD/SUB update flags.
- Addresses/jump targets use low AW bits of the word. PC increments mod 2^AW (wraps 2^AW−1 → 0).
- States: FETCH (address = pc, read) → DECODE (latch opcode, pc+1; operand-bearing → OPERAND, HALT → HALTED, illegal → ERROR, else EXEC) → OPERAND (latch operand, pc+1) → EXEC. EXEC: PUSHC push imm → FETCH; PUSH issue read of operand → MEMRD (push ram_data_in) → FETCH; POP pop, write tos to mem[operand] → FETCH; JUMP/JZ/JS pop, conditional pc load → FETCH; ADD/SUB latch a, pop → EXEC2 latch b, pop → WB push result, flags → FETCH.
- Traps checked in the state that would strobe: pop with stack_empty → ERROR code 1; push with stack_full → ERROR code 2 (ADD/SUB WB cannot overflow: two pops precede it). Trapping state issues no strobe, no RAM write, no PC/flag change.
- ERROR and HALTED are terminal until resetN; error/halted stay 1.
- haltN=0: state and registers frozen, strobes 0, ram_readWriteN 1; resumes the same state on haltN=1.
- Reset values: state FETCH, pc = RESET_PC, ram_address = RESET_PC, ram_readWriteN 1, ram_data_out 0, stack_data_out 0, strobes 0, flags 0, halted 0, error 0, err_code 0. Reset mid-instruction aborts it without completing strobes.

## Timing
- Strobes and RAM write are single-cycle, decoded from state and gated by haltN; stack samples on the same clk edge.
- Cycles per instruction (haltN=1): PUSHC 4, PUSH 5, POP 4, JUMP/JZ/JS 3, ADD/SUB 5, HALT 2 to HALTED.
- After a pop, stack_data_in shows the new top the next cycle; EXEC2 relies on this.
- POP: ram_readWriteN=0, ram_address=operand, ram_data_out=tos in the EXEC cycle.

## Structure
- Package stack_cpu_pkg: opcode constants, state encoding, err_code constants.
- Sub-module stack_cpu_alu: combinational DW-bit add/sub with z/s outputs.
- Core FSM, PC, operand/a/b registers in stack_cpu.

## Test plan
- Program PUSHC 5, PUSHC 3, SUB, POP 0x40, HALT -> mem[0x40]=2, z=0, s=0, halted=1 after 4+4+5+4+2 cycles.
- PUSHC 3, PUSHC 3, SUB, PUSHC 0x10, JZ at 0x10 HALT -> pc reaches 0x10, z=1, stack empty.
- DW=8: PUSHC 0x01, PUSHC 0x02, SUB -> result 0xFF, s=1; ADD 0xFF+0x01 -> 0x00, z=1.
- JUMP with stack_empty=1 -> error=1, err_code=1, no stack_pop; PUSHC with stack_full=1 -> err_code=2; opcode 0xB -> err_code=3.
- haltN low 3 cycles during ADD EXEC2 -> no strobes while low, result identical to unfrozen run.
- resetN low mid-PUSH, AW=4 run with PC wrap 15→0 -> all outputs at reset values, execution restarts at RESET_PC.

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU: opcodes, FSM state encoding and trap codes.
package stack_cpu_pkg;

  localparam logic [3:0] OP_PUSHC = 4'd0;
  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_JUMP  = 4'd3;
  localparam logic [3:0] OP_JZ    = 4'd4;
  localparam logic [3:0] OP_JS    = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd8;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_OPERAND, ST_EXEC, ST_MEMRD,
    ST_EXEC2, ST_WB, ST_HALTED, ST_ERROR
  } state_t;

  function automatic logic has_operand(input logic [3:0] op);
    return op <= OP_POP;
  endfunction

  // POP, JUMP, JZ, JS, ADD and SUB all pop the top of stack in EXEC
  function automatic logic pops_in_exec(input logic [3:0] op);
    return (op >= OP_POP) && (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/stack_cpu_alu.sv
// Combinational add/subtract for the stack CPU; result is b+a or b-a with zero/sign flags.
module stack_cpu_alu
  import stack_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          s
);

  assign result = sub ? (b - a) : (b + a);
  assign z      = (result == '0);
  assign s      = result[DW-1];

endmodule

// File: rtl/stack_cpu.sv
// Multicycle stack-machine core: fetches from a synchronous RAM, executes against a FWFT stack.
module stack_cpu
  import stack_cpu_pkg::*;
#(
  parameter int             DW       = 8,
  parameter int             AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          haltN,
  output logic [AW-1:0] ram_address,
  output logic          ram_readWriteN,
  output logic [DW-1:0] ram_data_out,
  input  logic [DW-1:0] ram_data_in,
  output logic [DW-1:0] stack_data_out,
  input  logic [DW-1:0] stack_data_in,
  output logic          stack_push,
  output logic          stack_pop,
  input  logic          stack_full,
  input  logic          stack_empty,
  output logic          z_flag,
  output logic          s_flag,
  output logic          halted,
  output logic          error,
  output logic [1:0]    err_code
);

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  logic [3:0]    op;
  logic [DW-1:0] operand;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] alu_res;
  logic          alu_z;
  logic          alu_s;

  assign pc_inc = pc + AW'(1);

  stack_cpu_alu #(.DW(DW)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .sub    (op == OP_SUB),
    .result (alu_res),
    .z      (alu_z),
    .s      (alu_s)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      op       <= OP_PUSHC;
      z_flag   <= 1'b0;
      s_flag   <= 1'b0;
      err_code <= ERR_NONE;
    end else if (haltN) begin
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          op <= ram_data_in[3:0];
          if (ram_data_in[3:0] > OP_HALT) begin
            state    <= ST_ERROR;
            err_code <= ERR_ILLEGAL;
          end else begin
            pc <= pc_inc;
            if (has_operand(ram_data_in[3:0]))   state <= ST_OPERAND;
            else if (ram_data_in[3:0] == OP_HALT) state <= ST_HALTED;
            else                                   state <= ST_EXEC;
          end
        end
        ST_OPERAND: begin
          pc    <= pc_inc;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op == OP_PUSH) begin
            state <= ST_MEMRD;
          end else if (op == OP_PUSHC) begin
            state    <= stack_full ? ST_ERROR : ST_FETCH;
            err_code <= stack_full ? ERR_OVERFLOW : ERR_NONE;
          end else if (stack_empty) begin
            state    <= ST_ERROR;
            err_code <= ERR_UNDERFLOW;
          end else if (op == OP_ADD || op == OP_SUB) begin
            state <= ST_EXEC2;
          end else begin
            state <= ST_FETCH;
            if ((op == OP_JUMP) || (op == OP_JZ && z_flag) || (op == OP_JS && s_flag))
              pc <= stack_data_in[AW-1:0];
          end
        end
        ST_MEMRD: begin
          state    <= stack_full ? ST_ERROR : ST_FETCH;
          err_code <= stack_full ? ERR_OVERFLOW : ERR_NONE;
        end
        ST_EXEC2: begin
          state    <= stack_empty ? ST_ERROR : ST_WB;
          err_code <= stack_empty ? ERR_UNDERFLOW : ERR_NONE;
        end
        ST_WB: begin
          z_flag <= alu_z;
          s_flag <= alu_s;
          state  <= ST_FETCH;
        end
        default: state <= state;
      endcase
    end
  end

  // Operand and ALU operands are pure datapath; they need no reset
  always_ff @(posedge clk) begin
    if (haltN) begin
      if (state == ST_OPERAND) operand <= ram_data_in;
      if (state == ST_EXEC)    a_reg   <= stack_data_in;
      if (state == ST_EXEC2)   b_reg   <= stack_data_in;
    end
  end

  // While frozen, keep presenting the address whose read data the current state consumes
  always_comb begin
    ram_address    = pc;
    ram_readWriteN = 1'b1;
    ram_data_out   = '0;
    stack_data_out = '0;
    stack_push     = 1'b0;
    stack_pop      = 1'b0;
    case (state)
      ST_DECODE: if (haltN) ram_address = pc_inc;
      ST_EXEC:   ram_address = operand[AW-1:0];
      ST_MEMRD:  if (!haltN) ram_address = operand[AW-1:0];
      default:   ;
    endcase
    if (haltN) begin
      case (state)
        ST_EXEC: begin
          if (op == OP_PUSHC && !stack_full) begin
            stack_push     = 1'b1;
            stack_data_out = operand;
          end
          if (pops_in_exec(op) && !stack_empty) begin
            stack_pop = 1'b1;
            if (op == OP_POP) begin
              ram_readWriteN = 1'b0;
              ram_data_out   = stack_data_in;
            end
          end
        end
        ST_MEMRD: begin
          if (!stack_full) begin
            stack_push     = 1'b1;
            stack_data_out = ram_data_in;
          end
        end
        ST_EXEC2: stack_pop = !stack_empty;
        ST_WB: begin
          stack_push     = 1'b1;
          stack_data_out = alu_res;
        end
        default: ;
      endcase
    end
  end

  assign halted = (state == ST_HALTED);
  assign error  = (state == ST_ERROR);

endmodule
